// File: rtl/cyclic_codec_if.sv
// Handshake and result bundle between the serial cyclic codec and its source/sink.
// The master drives start/mode and the input stream; the slave returns the coded stream and syndrome.
interface cyclic_codec_if #(
  parameter int R = 9
);
  logic         start;
  logic         mode;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         out_valid;
  logic         out_bit;
  logic         out_last;
  logic [R-1:0] syn;
  logic         syn_valid;
  logic         err;

  modport master (
    output start, mode, in_valid, in_bit,
    input  busy, in_ready, out_valid, out_bit, out_last, syn, syn_valid, err
  );

  modport slave (
    input  start, mode, in_valid, in_bit,
    output busy, in_ready, out_valid, out_bit, out_last, syn, syn_valid, err
  );
endinterface

// File: rtl/cyclic_codec.sv
// Serial cyclic-code engine: systematic encoder (message then parity) or codeword checker (syndrome, err).
// Output register adds 1 cycle; input stalls via in_ready/in_valid, parity phase never stalls, no output back-pressure.
module cyclic_codec #(
  parameter int           K    = 55,
  parameter int           R    = 9,
  parameter logic [R-1:0] POLY = 9'h011
) (
  input logic           clk,
  input logic           rst,
  cyclic_codec_if.slave bus
);
  localparam int N  = K + R;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] R_LAST = CW'(R - 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, MSG, PAR, CHK} state_t;

  state_t        state_q, state_d;
  logic [R-1:0]  s_q, s_d;
  logic [R-1:0]  syn_q, syn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_bit_q, out_bit_d;
  logic          out_last_q, out_last_d;
  logic          syn_valid_q, syn_valid_d;
  logic          err_q, err_d;
  logic          xfer;
  logic          fb;

  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == MSG) || (state_q == CHK);
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
  assign bus.syn       = syn_q;
  assign bus.syn_valid = syn_valid_q;
  assign bus.err       = err_q;

  assign xfer = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_last_d  = 1'b0;
    syn_d       = syn_q;
    syn_valid_d = 1'b0;
    err_d       = err_q;
    fb          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = '0;
          cnt_d   = '0;
          syn_d   = '0;
          err_d   = 1'b0;
          state_d = bus.mode ? CHK : MSG;
        end
      end
      MSG: begin
        if (xfer) begin
          // Premultiplied divider: the message enters at the top, so s holds m(x)*x^R mod g(x).
          fb          = bus.in_bit ^ s_q[R-1];
          s_d         = {s_q[R-2:0], 1'b0} ^ ({R{fb}} & POLY);
          out_valid_d = 1'b1;
          out_bit_d   = bus.in_bit;
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PAR: begin
        out_valid_d = 1'b1;
        out_bit_d   = s_q[R-1];
        s_d         = {s_q[R-2:0], 1'b0};
        if (cnt_q == R_LAST) begin
          out_last_d = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHK: begin
        if (xfer) begin
          // Plain divider: bits enter at the bottom, leaving c(x) mod g(x) after N shifts.
          fb  = s_q[R-1];
          s_d = {s_q[R-2:0], bus.in_bit} ^ ({R{fb}} & POLY);
          if (cnt_q == N_LAST) begin
            syn_d       = s_d;
            err_d       = |s_d;
            syn_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: doc/cyclic_codec.md
# cyclic_codec

Parametrised serial cyclic-code engine: the successor to the fixed 9-bit divider register. It has a generic generator polynomial, message/parity lengths, a start/handshake sequencer and two modes:
- systematic encoding (message passthrough followed by parity);
- codeword checking (syndrome plus error flag).

It sits between the bit-serial message source and the channel/decoder path.

## Interface
- K, 55, message length in bits (K ≥ 1)
- R, 9, parity/remainder length = degree of g(x) (R ≥ 2)
- POLY, 9'h011, coefficients g_0..g_{R-1} (bit i = g_i); g_R = 1 implicit; default g(x) = x^9 + x^4 + 1
- N (localparam) = K + R, codeword length; counter width $clog2(N+1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin an operation; sampled only in IDLE
- mode  in  1  sampled with start: 0 = encode, 1 = check
- busy  out  1  high whenever state ≠ IDLE
- in_valid  in  1  source has in_bit
- in_ready  out  1  high in MSG and CHK states only
- in_bit  in  1  serial input, MSB (highest-degree coefficient) first
- out_valid  out  1  registered; out_bit valid this cycle
- out_bit  out  1  registered encoded stream
- out_last  out  1  high with the final parity bit
- syn  out  R  registered syndrome, held until the next accepted start
- syn_valid  out  1  one-cycle pulse when syn is updated
- err  out  1  |syn, held with syn

## Operation
- States: IDLE, MSG, PAR, CHK.
- Transfer = in_valid & in_ready.
- IDLE + start:
  - clear remainder s[R-1:0] and counter cnt;
  - go to MSG if mode = 0, CHK if mode = 1.
- start while busy is ignored.
- MSG, per transfer:
  - fb = in_bit ^ s[R-1];
  - s_next[0] = fb & g_0;
  - s_next[i] = s[i-1] ^ (fb & g_i);
  - next cycle: out_valid = 1, out_bit = in_bit;
  - cnt++.
  - On the K-th transfer, go to PAR with cnt = 0.
- PAR, every cycle (no input consumed):
  - out_bit <= s[R-1], out_valid <= 1;
  - s shifts left, zero fill;
  - cnt++.
  - On the R-th PAR cycle: out_last is set for the bit it loads, then go to IDLE.
- CHK, per transfer:
  - fb = s[R-1];
  - s_next[0] = in_bit ^ (fb & g_0);
  - s_next[i] = s[i-1] ^ (fb & g_i);
  - out_valid stays 0.
  - On the N-th transfer: next cycle syn = s_next, err = |s_next, syn_valid = 1 for that one cycle; go to IDLE.
- Result: the encoded word is c(x) = m(x)·x^R + (m(x)·x^R mod g(x)); syn = c(x) mod g(x).
- Reset (any time, including mid-operation) forces:
  - state = IDLE, s = 0, cnt = 0;
  - out_valid = out_bit = out_last = 0;
  - syn = 0, syn_valid = 0, err = 0, busy = 0, in_ready = 0.
- An aborted word produces no further output.

## Timing
- Out-register latency is 1 cycle: a message transfer at cycle t gives out_valid at t+1.
- Last message transfer at t:
  - parity bits appear at t+2 .. t+R+1;
  - out_last at t+R+1;
  - busy falls at t+R+1.
- The t+1 gap is filled by the last message bit, so the output is gap-free.
- With in_valid held high from the cycle after start, output is K+R contiguous valid cycles.
- Input bubbles:
  - in_valid low produces out_valid low bubbles in MSG;
  - PAR is never stalled;
  - there is no output back-pressure.
- start accepted at cycle t: in_ready is high from t+1.
- start in the same cycle out_last is shown is accepted, because state is already IDLE.
- CHK: N-th transfer at t gives syn_valid/syn/err at t+1 and busy low at t+1.

## Test plan
- Reset, then encode a K = 55 all-zero message with in_valid held high -> 64 contiguous out_valid cycles, all out_bit = 0, out_last only on cycle 64.
- Encode m(x) = 1 (54 zeros then a one) -> parity stream 0,0,0,0,1,0,0,0,1; out_last on the final 1.
- Check the codeword from the previous test -> syn = 9'h000, err = 0, syn_valid pulses exactly once. Repeat with the last bit flipped -> syn = 9'h001, err = 1.
- Encode a random message with in_valid toggling pseudo-randomly -> parity identical to the gap-free run; out_valid bubbles match input bubbles; no parity bubbles.
- Pulse start mid-MSG -> ignored; no state or count change.
- Assert rst mid-PAR -> all outputs 0 the same cycle; a subsequent fresh encode is correct.
- Check each single-bit error position 0..63 on the all-zero codeword -> err = 1 and syn ≠ 0 for every position.
